// File: rtl/wb32_to_wb8_bridge_pkg.sv
// Shared types and constants for the 32-to-8 bit Wishbone width adapter.
package wb_bridge_pkg;

   localparam int LANES     = 4;
   localparam int LANE_BITS = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Returns one byte lane of a 32-bit word.
   function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [LANE_BITS-1:0] lane);
      return w[{lane, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/wb32_to_wb8_bridge_if.sv
// Bus bundle for the bridge: 32-bit upstream Wishbone side plus 8-bit downstream RAM side.
interface wb32_to_wb8_bridge_if #(
   parameter int ADDR_WIDTH = 10
);
   logic                  STB_I;
   logic                  WE_I;
   logic [ADDR_WIDTH-1:0] ADR_I;
   logic [3:0]            SEL_I;
   logic [31:0]           DAT_I;
   logic [31:0]           DAT_O;
   logic                  ACK_O;
   logic                  M_STB_O;
   logic                  M_WE_O;
   logic [ADDR_WIDTH-1:0] M_ADR_O;
   logic [7:0]            M_DAT_O;
   logic [7:0]            M_DAT_I;
   logic                  M_ACK_I;

   // slave: the bridge itself; master: the CPU and RAM surrounding it
   modport slave (
      input  STB_I, WE_I, ADR_I, SEL_I, DAT_I, M_DAT_I, M_ACK_I,
      output DAT_O, ACK_O, M_STB_O, M_WE_O, M_ADR_O, M_DAT_O
   );

   modport master (
      output STB_I, WE_I, ADR_I, SEL_I, DAT_I, M_DAT_I, M_ACK_I,
      input  DAT_O, ACK_O, M_STB_O, M_WE_O, M_ADR_O, M_DAT_O
   );
endinterface

// File: rtl/wb32_to_wb8_bridge_picker.sv
// Lowest-set-bit encoder over the pending byte-lane mask.
module byte_lane_picker
   import wb_bridge_pkg::*;
(
   input  logic [LANES-1:0]     mask,
   output logic [LANE_BITS-1:0] lane,
   output logic                 any
);

   always_comb begin
      lane = '0;
      any  = |mask;
      // Descending scan so the lowest set lane is the last to overwrite.
      for (int i = LANES - 1; i >= 0; i--) begin
         if (mask[i]) lane = LANE_BITS'(i);
      end
   end

endmodule

// File: rtl/wb32_to_wb8_bridge.sv
// Splits each 32-bit Wishbone request into single-byte accesses on an 8-bit slave,
// reassembling read bytes and returning one upstream acknowledge per request.
module wb32_to_wb8_bridge
   import wb_bridge_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic CLK_I,
   input  logic RST_N_I,
   wb32_to_wb8_bridge_if.slave bus
);

   state_t                 state_q, state_d;
   logic                   we_q, we_d;
   logic [ADDR_WIDTH-1:2]  adr_q, adr_d;
   logic [31:0]            wdat_q, wdat_d;
   logic [31:0]            asm_q, asm_d;
   logic [LANES-1:0]       pend_q, pend_d;
   logic [LANE_BITS-1:0]   lane_q, lane_d;

   logic [LANES-1:0]       pick_mask;
   logic [LANE_BITS-1:0]   pick_lane;
   logic                   pick_any;

   logic                   ack_q, ack_d;
   logic [31:0]            rdat_q, rdat_d;
   logic                   m_stb_q, m_stb_d;
   logic                   m_we_q, m_we_d;
   logic [ADDR_WIDTH-1:0]  m_adr_q, m_adr_d;
   logic [7:0]             m_dat_q, m_dat_d;

   logic                   unused_ok;
   assign unused_ok = ^bus.ADR_I[1:0];

   // IDLE picks from the incoming selects, GAP from what is still pending.
   assign pick_mask = (state_q == IDLE) ? bus.SEL_I : pend_q;

   byte_lane_picker u_picker (
      .mask (pick_mask),
      .lane (pick_lane),
      .any  (pick_any)
   );

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      asm_d   = asm_q;
      pend_d  = pend_q;
      lane_d  = lane_q;

      case (state_q)
         IDLE: begin
            if (bus.STB_I) begin
               we_d    = bus.WE_I;
               adr_d   = bus.ADR_I[ADDR_WIDTH-1:2];
               wdat_d  = bus.DAT_I;
               asm_d   = '0;
               pend_d  = bus.SEL_I;
               lane_d  = pick_lane;
               state_d = pick_any ? ISSUE : DONE;
            end
         end
         ISSUE: begin
            if (bus.M_ACK_I) begin
               if (!we_q) asm_d[{lane_q, 3'b000} +: 8] = bus.M_DAT_I;
               pend_d  = pend_q & ~(LANES'(1) << lane_q);
               state_d = (|pend_d) ? GAP : DONE;
            end
         end
         GAP: begin
            // One strobe-low cycle lets the slave's registered ack fall.
            lane_d  = pick_lane;
            state_d = ISSUE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are registered from the next state so they line up with it.
      m_stb_d = (state_d == ISSUE);
      m_we_d  = m_stb_d & we_d;
      m_adr_d = m_stb_d ? {adr_d, lane_d} : '0;
      m_dat_d = m_stb_d ? lane_byte(wdat_d, lane_d) : 8'h00;
      ack_d   = (state_d == DONE);
      rdat_d  = (ack_d && !we_d) ? asm_d : 32'h0;
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         adr_q   <= '0;
         wdat_q  <= '0;
         asm_q   <= '0;
         pend_q  <= '0;
         lane_q  <= '0;
         ack_q   <= 1'b0;
         rdat_q  <= '0;
         m_stb_q <= 1'b0;
         m_we_q  <= 1'b0;
         m_adr_q <= '0;
         m_dat_q <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         asm_q   <= asm_d;
         pend_q  <= pend_d;
         lane_q  <= lane_d;
         ack_q   <= ack_d;
         rdat_q  <= rdat_d;
         m_stb_q <= m_stb_d;
         m_we_q  <= m_we_d;
         m_adr_q <= m_adr_d;
         m_dat_q <= m_dat_d;
      end
   end

   assign bus.ACK_O   = ack_q;
   assign bus.DAT_O   = rdat_q;
   assign bus.M_STB_O = m_stb_q;
   assign bus.M_WE_O  = m_we_q;
   assign bus.M_ADR_O = m_adr_q;
   assign bus.M_DAT_O = m_dat_q;

endmodule

// File: tb/tb_wb32_to_wb8_bridge.sv
// Bench for wb32_to_wb8_bridge against a one-wait-state 8-bit RAM model.
module tb_wb32_to_wb8_bridge;

   localparam int AW = 10;

   typedef struct {
      logic [31:0] dat;
      int          cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   wb32_to_wb8_bridge_if #(.ADDR_WIDTH(AW)) bus();

   wb32_to_wb8_bridge #(.ADDR_WIDTH(AW)) dut (
      .CLK_I   (clk),
      .RST_N_I (rst_n),
      .bus     (bus)
   );

   logic [7:0] mem     [0:(1<<AW)-1];
   logic [7:0] exp_mem [0:(1<<AW)-1];
   exp_t       sb[$];
   int         n_vec = 0;
   int         n_err = 0;

   // RAM: registered ack and read data, ack follows strobe by one cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.M_ACK_I <= 1'b0;
         bus.M_DAT_I <= 8'h00;
      end else begin
         bus.M_ACK_I <= bus.M_STB_O;
         if (bus.M_STB_O) begin
            if (bus.M_WE_O) mem[bus.M_ADR_O] <= bus.M_DAT_O;
            bus.M_DAT_I <= mem[bus.M_ADR_O];
         end
      end
   end

   // Downstream monitor: strobe pulse addresses, gap lengths, ISSUE stability.
   logic [AW-1:0] stb_adr[$];
   int            gap_bad = 0;
   int            stab_bad = 0;
   int            low_run = 0;
   logic          prev_stb = 1'b0;
   logic          prev_we = 1'b0;
   logic [AW-1:0] prev_adr = '0;
   logic [7:0]    prev_dat = '0;

   always @(negedge clk) begin
      if (bus.M_STB_O === 1'b1) begin
         if (!prev_stb) begin
            stb_adr.push_back(bus.M_ADR_O);
            if (stb_adr.size() > 1 && low_run != 1) gap_bad++;
         end else if (bus.M_ADR_O !== prev_adr || bus.M_DAT_O !== prev_dat || bus.M_WE_O !== prev_we) begin
            stab_bad++;
         end
         low_run = 0;
      end else begin
         low_run++;
      end
      prev_stb = (bus.M_STB_O === 1'b1);
      prev_adr = bus.M_ADR_O;
      prev_dat = bus.M_DAT_O;
      prev_we  = bus.M_WE_O;
   end

   // Pushes the model's expectation, then presents the request before the next edge.
   task automatic issue(input logic we, input logic [AW-1:0] adr, input logic [3:0] sel,
                        input logic [31:0] dat);
      exp_t e;
      int   n;
      n = 0;
      e.dat = 32'h0;
      for (int l = 0; l < 4; l++) begin
         if (sel[l]) begin
            n++;
            if (we) exp_mem[{adr[AW-1:2], 2'(l)}] = dat[8*l +: 8];
            else    e.dat[8*l +: 8] = exp_mem[{adr[AW-1:2], 2'(l)}];
         end
      end
      e.cyc = (n == 0) ? 1 : 3 * n;
      sb.push_back(e);
      @(negedge clk);
      stb_adr.delete();
      gap_bad  = 0;
      stab_bad = 0;
      low_run  = 0;
      bus.STB_I = 1'b1;
      bus.WE_I  = we;
      bus.ADR_I = adr;
      bus.SEL_I = sel;
      bus.DAT_I = dat;
   endtask

   // Waits for ACK_O (bounded); optionally changes ADR_I/DAT_I in cycle hold_at.
   task automatic wait_ack(input int hold_at, output int cyc, output logic [31:0] d,
                           output logic ack_next);
      cyc = -1;
      d = 32'hx;
      for (int c = 1; c <= 60; c++) begin
         @(negedge clk);
         if (c == hold_at) begin
            bus.ADR_I = 10'h008;
            bus.DAT_I = 32'hFFFF_FFFF;
         end
         if (bus.ACK_O === 1'b1) begin
            cyc = c;
            d = bus.DAT_O;
            break;
         end
      end
      bus.STB_I = 1'b0;
      @(negedge clk);
      ack_next = bus.ACK_O;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      n_vec++;
      if ({bus.ACK_O, bus.M_STB_O, bus.M_WE_O} !== 3'b000) begin
         n_err++;
         $display("FAIL reset_ctl got ack/stb/we=%b want 000", {bus.ACK_O, bus.M_STB_O, bus.M_WE_O});
      end
      n_vec++;
      if ({bus.DAT_O, bus.M_ADR_O, bus.M_DAT_O} !== '0) begin
         n_err++;
         $display("FAIL reset_data got dat_o=%h m_adr=%h m_dat=%h want 0", bus.DAT_O, bus.M_ADR_O, bus.M_DAT_O);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_word_write();
      exp_t e;
      int cyc;
      logic [31:0] d;
      logic an;
      issue(1'b1, 10'h004, 4'b1111, 32'hDDCC_BBAA);
      wait_ack(0, cyc, d, an);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== e.cyc) begin n_err++; $display("FAIL wr_latency got %0d want %0d", cyc, e.cyc); end
      n_vec++;
      if (an !== 1'b0) begin n_err++; $display("FAIL wr_ack_width got ack still %b want 0", an); end
      n_vec++;
      if (gap_bad !== 0 || stab_bad !== 0) begin
         n_err++; $display("FAIL wr_gap got gap_bad=%0d stab_bad=%0d want 0/0", gap_bad, stab_bad);
      end
      for (int a = 4; a < 8; a++) begin
         n_vec++;
         if (mem[a] !== exp_mem[a]) begin n_err++; $display("FAIL wr_ram[%0d] got %h want %h", a, mem[a], exp_mem[a]); end
      end
   endtask

   task automatic test_word_read();
      exp_t e;
      int cyc;
      logic [31:0] d;
      logic an;
      issue(1'b0, 10'h004, 4'b1111, 32'h0);
      wait_ack(0, cyc, d, an);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== e.cyc) begin n_err++; $display("FAIL rd_latency got %0d want %0d", cyc, e.cyc); end
      n_vec++;
      if (d !== e.dat) begin n_err++; $display("FAIL rd_data got %h want %h", d, e.dat); end
      n_vec++;
      if (stb_adr.size() !== 4) begin n_err++; $display("FAIL rd_pulses got %0d want 4", stb_adr.size()); end
      for (int i = 0; i < 4 && i < stb_adr.size(); i++) begin
         n_vec++;
         if (stb_adr[i] !== AW'(4 + i)) begin n_err++; $display("FAIL rd_adr[%0d] got %h want %h", i, stb_adr[i], 4 + i); end
      end
   endtask

   task automatic test_sparse();
      exp_t e;
      int cyc;
      logic [31:0] d;
      logic an;
      issue(1'b0, 10'h004, 4'b1010, 32'h0);
      wait_ack(0, cyc, d, an);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== e.cyc) begin n_err++; $display("FAIL sparse_latency got %0d want %0d", cyc, e.cyc); end
      n_vec++;
      if (d !== e.dat) begin n_err++; $display("FAIL sparse_data got %h want %h", d, e.dat); end
      n_vec++;
      if (stb_adr.size() !== 2) begin
         n_err++; $display("FAIL sparse_pulses got %0d want 2", stb_adr.size());
      end else begin
         n_vec++;
         if (stb_adr[0] !== AW'(5) || stb_adr[1] !== AW'(7)) begin
            n_err++; $display("FAIL sparse_adr got %h,%h want 005,007", stb_adr[0], stb_adr[1]);
         end
      end
   endtask

   task automatic test_sel_zero();
      exp_t e;
      int cyc;
      logic [31:0] d;
      logic an;
      issue(1'b1, 10'h004, 4'b0000, 32'h1234_5678);
      wait_ack(0, cyc, d, an);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== e.cyc) begin n_err++; $display("FAIL sel0_latency got %0d want %0d", cyc, e.cyc); end
      n_vec++;
      if (stb_adr.size() !== 0) begin n_err++; $display("FAIL sel0_pulses got %0d want 0", stb_adr.size()); end
      n_vec++;
      if (d !== 32'h0) begin n_err++; $display("FAIL sel0_data got %h want 0", d); end
      for (int a = 4; a < 8; a++) begin
         n_vec++;
         if (mem[a] !== exp_mem[a]) begin n_err++; $display("FAIL sel0_ram[%0d] got %h want %h", a, mem[a], exp_mem[a]); end
      end
   endtask

   task automatic test_input_hold();
      exp_t e;
      int cyc;
      logic [31:0] d;
      logic an;
      issue(1'b1, 10'h004, 4'b1111, 32'hA1B2_C3D4);
      wait_ack(2, cyc, d, an);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== e.cyc) begin n_err++; $display("FAIL hold_latency got %0d want %0d", cyc, e.cyc); end
      for (int a = 4; a < 12; a++) begin
         n_vec++;
         if (mem[a] !== exp_mem[a]) begin n_err++; $display("FAIL hold_ram[%0d] got %h want %h", a, mem[a], exp_mem[a]); end
      end
   endtask

   task automatic test_mid_reset();
      exp_t e;
      int cyc;
      logic [31:0] d;
      logic an;
      logic [7:0] keep6, keep7;
      keep6 = exp_mem[6];
      keep7 = exp_mem[7];
      issue(1'b1, 10'h004, 4'b1111, 32'h4433_2211);
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({bus.ACK_O, bus.M_STB_O, bus.M_WE_O, bus.DAT_O, bus.M_ADR_O, bus.M_DAT_O} !== '0) begin
         n_err++;
         $display("FAIL midrst_outputs got ack=%b stb=%b we=%b dat_o=%h adr=%h dat=%h want all 0",
                  bus.ACK_O, bus.M_STB_O, bus.M_WE_O, bus.DAT_O, bus.M_ADR_O, bus.M_DAT_O);
      end
      void'(sb.pop_front());
      exp_mem[6] = keep6;
      exp_mem[7] = keep7;
      bus.STB_I = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int a = 4; a < 8; a++) begin
         n_vec++;
         if (mem[a] !== exp_mem[a]) begin n_err++; $display("FAIL midrst_ram[%0d] got %h want %h", a, mem[a], exp_mem[a]); end
      end
      issue(1'b0, 10'h004, 4'b1111, 32'h0);
      wait_ack(0, cyc, d, an);
      e = sb.pop_front();
      n_vec++;
      if (cyc !== e.cyc) begin n_err++; $display("FAIL midrst_next_latency got %0d want %0d", cyc, e.cyc); end
      n_vec++;
      if (d !== e.dat) begin n_err++; $display("FAIL midrst_next_data got %h want %h", d, e.dat); end
   endtask

   initial begin
      bus.STB_I = 1'b0;
      bus.WE_I  = 1'b0;
      bus.ADR_I = '0;
      bus.SEL_I = 4'h0;
      bus.DAT_I = 32'h0;
      test_reset();
      test_word_write();
      test_word_read();
      test_sparse();
      test_sel_zero();
      test_input_hold();
      test_mid_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
